// File: rtl/rmap_status_pkg.sv
// Shared constants for the RMAP status monitor: error codes, register map, block ID.
// Also provides the error-code to sticky-flag mapping helper.
package rmap_status_pkg;

   localparam logic [7:0] ERR_SUCCESS          = 8'd0;
   localparam logic [7:0] ERR_GENERAL          = 8'd1;
   localparam logic [7:0] ERR_UNUSED_TYPE      = 8'd2;
   localparam logic [7:0] ERR_INVALID_KEY      = 8'd3;
   localparam logic [7:0] ERR_INVALID_DATA_CRC = 8'd4;
   localparam logic [7:0] ERR_EARLY_EOP        = 8'd5;
   localparam logic [7:0] ERR_TOO_MUCH_DATA    = 8'd6;
   localparam logic [7:0] ERR_EEP              = 8'd7;
   localparam logic [7:0] ERR_VERIFY_OVERRUN   = 8'd9;
   localparam logic [7:0] ERR_NOT_AUTHORISED   = 8'd10;
   localparam logic [7:0] ERR_RMW_LENGTH       = 8'd11;
   localparam logic [7:0] ERR_INVALID_LOG_ADDR = 8'd12;
   localparam logic [7:0] ERR_OTHER_MIN        = 8'd15;

   localparam logic [2:0] ADDR_WCNT     = 3'd0;
   localparam logic [2:0] ADDR_RCNT     = 3'd1;
   localparam logic [2:0] ADDR_MCNT     = 3'd2;
   localparam logic [2:0] ADDR_ECNT     = 3'd3;
   localparam logic [2:0] ADDR_ERRSTAT  = 3'd4;
   localparam logic [2:0] ADDR_ACNT     = 3'd5;
   localparam logic [2:0] ADDR_LCNT     = 3'd6;
   localparam logic [2:0] ADDR_BLOCK_ID = 3'd7;

   localparam logic [31:0] BLOCK_ID_DEFAULT = 32'h524D_5354;

   // Code 0 sets nothing; codes at or above 15 share the "other" flag.
   function automatic logic [15:0] flagOf(input logic [7:0] code);
      flagOf = '0;
      if (code >= ERR_OTHER_MIN)
         flagOf[15] = 1'b1;
      else if (code != ERR_SUCCESS)
         flagOf[code[3:0]] = 1'b1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear coinciding with an increment leaves the counter at 1.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= inc ? W'(1) : '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/rmap_status_monitor.sv
// RMAP target status monitor: event counters, sticky error flags, irq, read port.
// Define RMAP_STATUS_AUTH_CNT_EN to build the auth-failure counters (addr 5/6).
module rmap_status_monitor
   import rmap_status_pkg::*;
#(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] BLOCK_ID = BLOCK_ID_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rmapErrorCode,
   input  logic        errorIndication,
   input  logic        writeDataIndication,
   input  logic        readDataIndication,
   input  logic        rmwDataIndication,
   input  logic        addrInvalid,
   input  logic        dataLengthInvalid,
   input  logic [15:0] irq_mask,
   input  logic        rd_en,
   input  logic [2:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   input  logic        clr,
   output logic        irq
);

   logic [CNT_W-1:0] wcnt, rcnt, mcnt, ecnt;
   logic [7:0]       lastErrCode, lastCodeNext;
   logic [15:0]      errFlags, errFlagsNext;
   logic [31:0]      authAddr, authLen, regData;

   sat_counter #(.W(CNT_W)) uWcnt (
      .clk(clk), .rst(rst), .clr(clr),
      .inc(writeDataIndication), .cnt(wcnt));
   sat_counter #(.W(CNT_W)) uRcnt (
      .clk(clk), .rst(rst), .clr(clr),
      .inc(readDataIndication), .cnt(rcnt));
   sat_counter #(.W(CNT_W)) uMcnt (
      .clk(clk), .rst(rst), .clr(clr),
      .inc(rmwDataIndication), .cnt(mcnt));
   sat_counter #(.W(CNT_W)) uEcnt (
      .clk(clk), .rst(rst), .clr(clr),
      .inc(errorIndication), .cnt(ecnt));

`ifdef RMAP_STATUS_AUTH_CNT_EN
   logic [CNT_W-1:0] acnt, lcnt;

   sat_counter #(.W(CNT_W)) uAcnt (
      .clk(clk), .rst(rst), .clr(clr),
      .inc(addrInvalid), .cnt(acnt));
   sat_counter #(.W(CNT_W)) uLcnt (
      .clk(clk), .rst(rst), .clr(clr),
      .inc(dataLengthInvalid), .cnt(lcnt));

   assign authAddr = 32'(acnt);
   assign authLen  = 32'(lcnt);
`else
   logic unusedAuth;

   assign unusedAuth = addrInvalid ^ dataLengthInvalid;
   assign authAddr   = '0;
   assign authLen    = '0;
`endif

   // Clear takes effect first so a coincident error still lands.
   always_comb begin
      errFlagsNext = clr ? '0 : errFlags;
      lastCodeNext = clr ? '0 : lastErrCode;
      if (errorIndication) begin
         errFlagsNext = errFlagsNext | flagOf(rmapErrorCode);
         lastCodeNext = rmapErrorCode;
      end
   end

   always_comb begin
      regData = '0;
      unique case (rd_addr)
         ADDR_WCNT:     regData = 32'(wcnt);
         ADDR_RCNT:     regData = 32'(rcnt);
         ADDR_MCNT:     regData = 32'(mcnt);
         ADDR_ECNT:     regData = 32'(ecnt);
         ADDR_ERRSTAT:  regData = {8'h0, lastErrCode, errFlags};
         ADDR_ACNT:     regData = authAddr;
         ADDR_LCNT:     regData = authLen;
         ADDR_BLOCK_ID: regData = BLOCK_ID;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastErrCode <= '0;
         errFlags    <= '0;
         irq         <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
      end else begin
         lastErrCode <= lastCodeNext;
         errFlags    <= errFlagsNext;
         irq         <= |(errFlagsNext & irq_mask);
         rd_valid    <= rd_en;
         if (rd_en)
            rd_data <= regData;
      end
   end

endmodule

// File: tb/tb_rmap_status_monitor.sv
// Scoreboard bench for rmap_status_monitor (CNT_W=4 so saturation is reachable).
// Directed plan items followed by randomized traffic against a behavioural model.
module tb_rmap_status_monitor;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rmapErrorCode = '0;
   logic        errorIndication = 1'b0;
   logic        writeDataIndication = 1'b0;
   logic        readDataIndication = 1'b0;
   logic        rmwDataIndication = 1'b0;
   logic        addrInvalid = 1'b0;
   logic        dataLengthInvalid = 1'b0;
   logic [15:0] irq_mask = '0;
   logic        rd_en = 1'b0;
   logic [2:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        clr = 1'b0;
   logic        irq;

   int checks = 0;
   int failures = 0;

   rmap_status_monitor #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .rmapErrorCode(rmapErrorCode),
      .errorIndication(errorIndication),
      .writeDataIndication(writeDataIndication),
      .readDataIndication(readDataIndication),
      .rmwDataIndication(rmwDataIndication),
      .addrInvalid(addrInvalid),
      .dataLengthInvalid(dataLengthInvalid),
      .irq_mask(irq_mask),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .clr(clr), .irq(irq));

   always #5 clk = ~clk;

   typedef struct {
      bit          w, r, m, e, a, l, c, rd;
      logic [7:0]  code;
      logic [15:0] mask;
      logic [2:0]  addr;
   } stim_t;

   typedef struct {
      bit          valid;
      logic [31:0] data;
      bit          irq;
   } exp_t;

   exp_t expQ[$];

   // Reference model state
   int          mW, mR, mM, mE, mA, mL;
   logic [7:0]  mLast;
   logic [15:0] mFlags;
   logic [31:0] mHeld;

   function automatic stim_t idle(input logic [15:0] mask);
      stim_t s;
      s = '{default: 0};
      s.mask = mask;
      return s;
   endfunction

   function automatic int bump(input int v, input bit ev);
      if (ev && v < CMAX) return v + 1;
      return v;
   endfunction

   function automatic logic [31:0] modelRead(input logic [2:0] a);
      case (a)
         3'd0: return mW;
         3'd1: return mR;
         3'd2: return mM;
         3'd3: return mE;
         3'd4: return {8'h0, mLast, mFlags};
`ifdef RMAP_STATUS_AUTH_CNT_EN
         3'd5: return mA;
         3'd6: return mL;
`else
         3'd5: return 0;
         3'd6: return 0;
`endif
         default: return 32'h524D_5354;
      endcase
   endfunction

   task automatic modelReset();
      mW = 0; mR = 0; mM = 0; mE = 0; mA = 0; mL = 0;
      mLast = 0; mFlags = 0; mHeld = 0;
   endtask

   task automatic step(input stim_t s);
      exp_t x;
      @(negedge clk);
      #2;
      writeDataIndication = s.w;
      readDataIndication  = s.r;
      rmwDataIndication   = s.m;
      errorIndication     = s.e;
      rmapErrorCode       = s.code;
      addrInvalid         = s.a;
      dataLengthInvalid   = s.l;
      clr                 = s.c;
      irq_mask            = s.mask;
      rd_en               = s.rd;
      rd_addr             = s.addr;
      if (s.rd) mHeld = modelRead(s.addr);
      x.valid = s.rd;
      x.data  = mHeld;
      if (s.c) begin
         mW = 0; mR = 0; mM = 0; mE = 0; mA = 0; mL = 0;
         mLast = 0; mFlags = 0;
      end
      mW = bump(mW, s.w);
      mR = bump(mR, s.r);
      mM = bump(mM, s.m);
      mE = bump(mE, s.e);
      mA = bump(mA, s.a);
      mL = bump(mL, s.l);
      if (s.e) begin
         mLast = s.code;
         if (s.code >= 15) mFlags[15] = 1'b1;
         else if (s.code != 0) mFlags[s.code] = 1'b1;
      end
      x.irq = (mFlags & s.mask) != 0;
      @(posedge clk);
      expQ.push_back(x);
   endtask

   task automatic readReg(input logic [2:0] a, input logic [15:0] mask);
      stim_t s;
      s = idle(mask);
      s.rd = 1'b1;
      s.addr = a;
      step(s);
   endtask

   task automatic doReset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || irq !== 1'b0 || rd_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b irq=%b data=%h, want 0 0 0",
                  rd_valid, irq, rd_data);
      end
      writeDataIndication = 0; readDataIndication = 0;
      rmwDataIndication = 0; errorIndication = 0;
      addrInvalid = 0; dataLengthInvalid = 0;
      clr = 0; rd_en = 0;
      modelReset();
      @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t x;
         x = expQ.pop_front();
         checks += 3;
         if (rd_valid !== x.valid) begin
            failures++;
            $display("FAIL rd_valid: got %b want %b", rd_valid, x.valid);
         end
         if (rd_data !== x.data) begin
            failures++;
            $display("FAIL rd_data: got %h want %h", rd_data, x.data);
         end
         if (irq !== x.irq) begin
            failures++;
            $display("FAIL irq: got %b want %b", irq, x.irq);
         end
      end
   end

   initial begin
      stim_t s;
      logic [15:0] mask;
      modelReset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset contents, all eight addresses
      for (int i = 0; i < 8; i++) readReg(3'(i), 16'h0);

      // Write/read/RMW mix, including write+read together
      s = idle(0); s.w = 1; step(s);
      s = idle(0); s.w = 1; s.r = 1; step(s);
      s = idle(0); s.w = 1; s.m = 1; s.rd = 1; s.addr = 0; step(s);
      s = idle(0); s.r = 1; step(s);
      for (int i = 0; i < 3; i++) readReg(3'(i), 16'h0);

      // Error capture and irq
      s = idle(16'h0008); s.e = 1; s.code = 8'd3; step(s);
      s = idle(16'h0008); s.e = 1; s.code = 8'd12; step(s);
      readReg(3'd3, 16'h0008);
      readReg(3'd4, 16'h0008);
      s = idle(16'h8000); s.e = 1; s.code = 8'd200; step(s);
      s = idle(16'h8000); s.e = 1; s.code = 8'd0; step(s);
      readReg(3'd4, 16'h0000);

      // Saturation
      for (int i = 0; i < 20; i++) begin
         s = idle(0); s.w = 1; s.rd = 1; s.addr = 0; step(s);
      end
      readReg(3'd0, 16'h0);

      // clr coincident with write at wcnt=5, irq falls
      s = idle(16'hFFFF); s.c = 1; step(s);
      for (int i = 0; i < 5; i++) begin
         s = idle(16'hFFFF); s.w = 1; step(s);
      end
      s = idle(16'hFFFF); s.e = 1; s.code = 8'd5; step(s);
      readReg(3'd0, 16'hFFFF);
      s = idle(16'hFFFF); s.c = 1; s.w = 1; step(s);
      readReg(3'd0, 16'hFFFF);
      readReg(3'd4, 16'hFFFF);

      // Auth pulses
      s = idle(0); s.a = 1; step(s);
      s = idle(0); s.a = 1; s.l = 1; step(s);
      readReg(3'd5, 16'h0);
      readReg(3'd6, 16'h0);

      // Reset with a read in flight
      s = idle(0); s.rd = 1; s.addr = 3'd7; step(s);
      doReset();
      readReg(3'd4, 16'h0);

      // Randomized traffic
      mask = 16'($urandom);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 31) == 0) mask = 16'($urandom);
         if ($urandom_range(0, 299) == 0) doReset();
         s = idle(mask);
         s.w = $urandom_range(0, 1);
         s.r = $urandom_range(0, 1);
         s.m = $urandom_range(0, 3) == 0;
         s.e = $urandom_range(0, 3) == 0;
         s.code = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                              : 8'($urandom_range(0, 16));
         s.a = $urandom_range(0, 3) == 0;
         s.l = $urandom_range(0, 3) == 0;
         s.c = $urandom_range(0, 15) == 0;
         s.rd = $urandom_range(0, 3) != 0;
         s.addr = 3'($urandom_range(0, 7));
         step(s);
      end
      step(idle(mask));

      repeat (3) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

endmodule
